fu_wb_collector: RTL and testbench
==================================

Name: fu_wb_collector

Overview:
- Downstream neighbour of the execution functional units (ALU, multiplier, divider, memory, jump).
- Each FU raises a single-cycle finish pulse; its result is only valid in that cycle, because the pipelined multiplier output keeps changing afterwards.
- This block captures every finished result into a per-FU holding slot and arbitrates the slots onto one registered write-back (CDB) port with a valid/ready handshake.
- It also reports per-FU pending status to the issue logic.

Parameters:
- NUM_FU, 4, number of functional-unit inputs (2..8).
- XLEN, 32, result width.
- TAG_W, 5, destination tag width (register index or reservation-station id).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- fu_finish  in  NUM_FU  per-FU one-cycle finish pulse.
- fu_res  in  NUM_FU*XLEN  flattened results; FU i occupies bits [i*XLEN +: XLEN].
- fu_tag  in  NUM_FU*TAG_W  flattened destination tags, same packing as fu_res.
- wb_ready  in  1  consumer accepts the CDB word this cycle.
- cdb_valid  out  1  CDB word valid.
- cdb_data  out  XLEN  CDB result.
- cdb_tag  out  TAG_W  CDB destination tag.
- cdb_src  out  $clog2(NUM_FU)  index of the FU that produced the word.
- fu_pending  out  NUM_FU  slot i holds an undelivered result.
- ovf_err  out  NUM_FU  sticky: finish i arrived while slot i was full and not draining.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears:
  - all slot valids, cdb_valid, cdb_data, cdb_tag, cdb_src, ovf_err;
  - the round-robin pointer, to 0.
  - Reset overrides every same-cycle capture and transfer; in-flight results are discarded.
- Slots: one entry per FU holding valid, data and tag; fu_pending[i] = slot valid[i].
- Capture, on the edge ending the cycle in which fu_finish[i]=1:
  - if slot i is empty, or is being transferred in that same cycle: slot i <= {1, fu_res[i], fu_tag[i]};
  - otherwise the existing entry is kept, the new result is dropped, and ovf_err[i] <= 1.
- Output register load condition: load = any slot valid && (!cdb_valid || wb_ready).
- On load:
  - the granted slot g moves to {cdb_data, cdb_tag, cdb_src=g}, cdb_valid <= 1;
  - slot g is cleared unless it is recaptured in the same cycle.
- If cdb_valid && wb_ready && no slot is valid: cdb_valid <= 0.
- If cdb_valid && !wb_ready: cdb_valid, cdb_data, cdb_tag and cdb_src hold stable.
- Arbitration (default, round-robin):
  - search from pointer p upward with wrap-around; the first valid slot wins;
  - after a load, p <= (g+1) mod NUM_FU; without a load, p holds.
- Latency: finish at cycle t -> slot valid at t+1 -> cdb_valid at t+2 (with no contention and wb_ready=1).
- Throughput: one CDB word per cycle.
- Concurrency: simultaneous finishes on all FUs are all captured, and drain in NUM_FU consecutive cycles.
- fu_finish is sampled only as a level in the cycle it is high; there is no edge detection.

Optional Feature:
- Macro FU_WB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid slot wins; the pointer is not implemented.
- Undefined: round-robin as described above.

Decomposition:
- Package fu_wb_pkg:
  - constants NUM_FU_DEF, XLEN_DEF, TAG_W_DEF;
  - FU index localparams FU_ALU=0, FU_MUL=1, FU_DIV=2, FU_MEM=3;
  - typedef of the slot struct {valid, data, tag}.
- Sub-module fu_wb_rr_arb:
  - inputs: request vector, pointer;
  - outputs: grant index and any-grant;
  - combinational; replaced by a priority encoder under FU_WB_FIXED_PRIO_EN.

Test Plan:
- Single result, no contention:
  - stimulus: fu_finish=4'b0010, res=32'h0000_0038, tag=5'd7 at cycle t, wb_ready=1;
  - response: cdb_valid=1 at t+2 with data 32'h38, tag 7, src 1; fu_pending[1]=0 at t+2.
- All four finish together:
  - stimulus: results 32'h10,11,12,13, pointer=0, wb_ready=1;
  - response: CDB sources in consecutive cycles are 0,1,2,3; the next grant after a new finish on FU0 is again fair.
- Backpressure:
  - stimulus: wb_ready=0 for 3 cycles while cdb_valid=1;
  - response: cdb_data/tag/src are unchanged each cycle and pending slots stay set; the word transfers on the first wb_ready=1 cycle.
- Overflow:
  - stimulus: slot 2 full, wb_ready=0, FU2 finishes again with 32'hDEAD;
  - response: ovf_err[2]=1 stays sticky; the original slot-2 data is delivered later; 32'hDEAD never appears on the CDB.
- Drain plus recapture:
  - stimulus: slot 1 granted in the same cycle that FU1 finishes with 32'h99;
  - response: no ovf_err; 32'h99 is delivered on a later CDB cycle.
- Reset mid-operation:
  - stimulus: rst_n=0 for one edge with 3 slots pending and cdb_valid=1;
  - response: next cycle all outputs are 0; a FU0 finish after reset appears 2 cycles later with src 0.

Source files
------------

// File: rtl/fu_wb_pkg.sv
// Shared constants and types for the functional-unit write-back collector.
package fu_wb_pkg;

  localparam int unsigned NUM_FU_DEF = 4;
  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned TAG_W_DEF  = 5;

  localparam int unsigned FU_ALU = 0;
  localparam int unsigned FU_MUL = 1;
  localparam int unsigned FU_DIV = 2;
  localparam int unsigned FU_MEM = 3;

  typedef struct packed {
    logic                 valid;
    logic [XLEN_DEF-1:0]  data;
    logic [TAG_W_DEF-1:0] tag;
  } fu_wb_slot_t;

endpackage

// File: rtl/fu_wb_rr_arb.sv
// Slot arbiter: round-robin search starting at ptr with wrap-around.
// With FU_WB_FIXED_PRIO_EN defined it becomes a lowest-index priority
// encoder and the ptr port disappears.
module fu_wb_rr_arb
  import fu_wb_pkg::*;
#(
  parameter int unsigned N = NUM_FU_DEF,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
`ifndef FU_WB_FIXED_PRIO_EN
  input  logic [IW-1:0] ptr,
`endif
  output logic [IW-1:0] grant_idx_c,
  output logic          grant_any_c
);

  // Pick the winning request
  always_comb begin
    logic [IW-1:0] idx;
    grant_idx_c = '0;
    grant_any_c = 1'b0;
    idx         = '0;
`ifdef FU_WB_FIXED_PRIO_EN
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = IW'(i);
      if (req[idx]) begin
        grant_idx_c = idx;
        grant_any_c = 1'b1;
      end
    end
`else
    for (int unsigned k = 0; k < N; k++) begin
      idx = IW'((32'(ptr) + 32'(k)) % N);
      if (!grant_any_c && req[idx]) begin
        grant_idx_c = idx;
        grant_any_c = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/fu_wb_collector.sv
// Collects single-cycle FU finish pulses into per-FU holding slots and
// drains them onto one registered CDB port with valid/ready handshake.
// Optional macro FU_WB_FIXED_PRIO_EN: fixed lowest-index priority instead
// of round-robin (no pointer register).
module fu_wb_collector
  import fu_wb_pkg::*;
#(
  parameter int unsigned NUM_FU = NUM_FU_DEF,
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF,
  localparam int unsigned SW    = $clog2(NUM_FU)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_FU-1:0]       fu_finish,
  input  logic [NUM_FU*XLEN-1:0]  fu_res,
  input  logic [NUM_FU*TAG_W-1:0] fu_tag,
  input  logic                    wb_ready,
  output logic                    cdb_valid,
  output logic [XLEN-1:0]         cdb_data,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [SW-1:0]           cdb_src,
  output logic [NUM_FU-1:0]       fu_pending,
  output logic [NUM_FU-1:0]       ovf_err
);

  logic [NUM_FU-1:0] slot_vld;
  logic [XLEN-1:0]   slot_data [NUM_FU];
  logic [TAG_W-1:0]  slot_tag  [NUM_FU];

  logic [SW-1:0]     grant_idx_c;
  logic              grant_any_c;
  logic              load_c;
  logic [NUM_FU-1:0] take_c;
  logic [NUM_FU-1:0] cap_c;
  logic [NUM_FU-1:0] ovf_set_c;

`ifndef FU_WB_FIXED_PRIO_EN
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] rr_ptr_nxt_c;
`endif

  fu_wb_rr_arb #(.N(NUM_FU)) u_arb (
    .req         (slot_vld),
`ifndef FU_WB_FIXED_PRIO_EN
    .ptr         (rr_ptr),
`endif
    .grant_idx_c (grant_idx_c),
    .grant_any_c (grant_any_c)
  );

  // Output-register load, per-slot drain, capture and overflow decisions
  always_comb begin
    load_c    = grant_any_c && (!cdb_valid || wb_ready);
    take_c    = '0;
    cap_c     = '0;
    ovf_set_c = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      take_c[i]    = load_c && (grant_idx_c == SW'(i));
      cap_c[i]     = fu_finish[i] && (!slot_vld[i] || take_c[i]);
      ovf_set_c[i] = fu_finish[i] && slot_vld[i] && !take_c[i];
    end
  end

  // Slot valid bits: recapture wins over drain in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_vld <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (cap_c[i])       slot_vld[i] <= 1'b1;
        else if (take_c[i]) slot_vld[i] <= 1'b0;
      end
    end
  end

  // Slot payload, only meaningful while the matching valid bit is set
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (cap_c[i]) begin
        slot_data[i] <= fu_res[i*XLEN +: XLEN];
        slot_tag[i]  <= fu_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // CDB output register: load granted slot, or drop valid once consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_tag   <= '0;
      cdb_src   <= '0;
    end else if (load_c) begin
      cdb_valid <= 1'b1;
      cdb_data  <= slot_data[grant_idx_c];
      cdb_tag   <= slot_tag[grant_idx_c];
      cdb_src   <= grant_idx_c;
    end else if (wb_ready) begin
      cdb_valid <= 1'b0;
    end
  end

  // Sticky overflow flags
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_err <= '0;
    else        ovf_err <= ovf_err | ovf_set_c;
  end

`ifndef FU_WB_FIXED_PRIO_EN
  // Next pointer sits just past the slot that was granted
  always_comb begin
    rr_ptr_nxt_c = (grant_idx_c == SW'(NUM_FU - 1)) ? '0 : grant_idx_c + SW'(1);
  end

  // Round-robin pointer advances only on a load
  always_ff @(posedge clk) begin
    if (!rst_n)      rr_ptr <= '0;
    else if (load_c) rr_ptr <= rr_ptr_nxt_c;
  end
`endif

  assign fu_pending = slot_vld;

endmodule

// File: tb/tb_fu_wb_collector.sv
// Directed bench for fu_wb_collector (default round-robin build) with a
// scoreboard of expected CDB words checked on every handshake.
module tb_fu_wb_collector;
  import fu_wb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned XW = 32;
  localparam int unsigned TW = 5;

  typedef struct packed {
    fu_wb_slot_t s;
    logic [1:0]  src;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    fu_finish;
  logic [N*XW-1:0] fu_res;
  logic [N*TW-1:0] fu_tag;
  logic            wb_ready;
  logic            cdb_valid;
  logic [XW-1:0]   cdb_data;
  logic [TW-1:0]   cdb_tag;
  logic [1:0]      cdb_src;
  logic [N-1:0]    fu_pending;
  logic [N-1:0]    ovf_err;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  fu_wb_collector #(.NUM_FU(N), .XLEN(XW), .TAG_W(TW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fu_finish  (fu_finish),
    .fu_res     (fu_res),
    .fu_tag     (fu_tag),
    .wb_ready   (wb_ready),
    .cdb_valid  (cdb_valid),
    .cdb_data   (cdb_data),
    .cdb_tag    (cdb_tag),
    .cdb_src    (cdb_src),
    .fu_pending (fu_pending),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [XW-1:0] r, input logic [TW-1:0] t);
    fu_finish[i]       = 1'b1;
    fu_res[i*XW +: XW] = r;
    fu_tag[i*TW +: TW] = t;
  endtask

  task automatic push(input logic [XW-1:0] r, input logic [TW-1:0] t, input logic [1:0] s);
    exp_t e;
    e.s.valid = 1'b1;
    e.s.data  = r;
    e.s.tag   = t;
    e.src     = s;
    exp_q.push_back(e);
  endtask

  task automatic chk_cdb(input string tag, input logic [XW-1:0] r, input logic [TW-1:0] t,
                         input logic [1:0] s);
    chk({tag, "_valid"}, 64'(cdb_valid), 64'(1));
    chk({tag, "_data"},  64'(cdb_data),  64'(r));
    chk({tag, "_tag"},   64'(cdb_tag),   64'(t));
    chk({tag, "_src"},   64'(cdb_src),   64'(s));
  endtask

  // Scoreboard: every accepted CDB word must match the next expected one
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cdb_valid === 1'b1 && wb_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed data %0h src %0d expected no word", cdb_data, cdb_src);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_data", 64'(cdb_data), 64'(e.s.data));
        chk("sb_tag",  64'(cdb_tag),  64'(e.s.tag));
        chk("sb_src",  64'(cdb_src),  64'(e.src));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    fu_finish = '0;
    fu_res    = '0;
    fu_tag    = '0;
    wb_ready  = 1'b1;
    tick();
    tick();
    chk("rst_valid",   64'(cdb_valid),  64'(0));
    chk("rst_data",    64'(cdb_data),   64'(0));
    chk("rst_src",     64'(cdb_src),    64'(0));
    chk("rst_pending", 64'(fu_pending), 64'(0));
    chk("rst_ovf",     64'(ovf_err),    64'(0));
    rst_n = 1'b1;
    tick();

    // All four finish together, then FU0 finishes again while others wait
    for (int i = 0; i < 4; i++) begin
      set_fu(i, XW'(32'h10 + i), TW'(i + 1));
      push(XW'(32'h10 + i), TW'(i + 1), 2'(i));
    end
    tick();
    fu_finish = '0;
    chk("all_pending", 64'(fu_pending), 64'(4'b1111));
    tick();
    chk_cdb("all0", 32'h10, 5'd1, 2'd0);
    set_fu(0, 32'h20, 5'd9);
    push(32'h20, 5'd9, 2'd0);
    tick();
    fu_finish = '0;
    chk_cdb("all1", 32'h11, 5'd2, 2'd1);
    tick();
    chk_cdb("all2", 32'h12, 5'd3, 2'd2);
    tick();
    chk_cdb("all3", 32'h13, 5'd4, 2'd3);
    tick();
    chk_cdb("fair0", 32'h20, 5'd9, 2'd0);
    tick();
    chk("all_idle", 64'(cdb_valid), 64'(0));

    // Single result, no contention
    set_fu(1, 32'h38, 5'd7);
    push(32'h38, 5'd7, 2'd1);
    tick();
    fu_finish = '0;
    chk("single_slot",  64'(fu_pending), 64'(4'b0010));
    chk("single_early", 64'(cdb_valid),  64'(0));
    tick();
    chk_cdb("single", 32'h38, 5'd7, 2'd1);
    chk("single_pend", 64'(fu_pending), 64'(0));
    tick();

    // Backpressure: CDB word and pending slot hold while wb_ready is low
    set_fu(0, 32'h50, 5'd3);
    set_fu(3, 32'h53, 5'd4);
    push(32'h53, 5'd4, 2'd3);
    push(32'h50, 5'd3, 2'd0);
    tick();
    fu_finish = '0;
    wb_ready  = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk_cdb("bp_hold", 32'h53, 5'd4, 2'd3);
      chk("bp_pend", 64'(fu_pending), 64'(4'b0001));
      tick();
    end
    chk_cdb("bp_hold", 32'h53, 5'd4, 2'd3);
    wb_ready = 1'b1;
    tick();
    chk_cdb("bp_next", 32'h50, 5'd3, 2'd0);
    tick();
    chk("bp_idle", 64'(cdb_valid), 64'(0));

    // Overflow: slot 2 full and stalled, FU2 finishes again
    wb_ready = 1'b0;
    set_fu(1, 32'h61, 5'd5);
    set_fu(2, 32'h62, 5'd6);
    push(32'h61, 5'd5, 2'd1);
    push(32'h62, 5'd6, 2'd2);
    tick();
    fu_finish = '0;
    tick();
    chk_cdb("ovf_cdb", 32'h61, 5'd5, 2'd1);
    set_fu(2, 32'hDEAD, 5'd31);
    tick();
    fu_finish = '0;
    chk("ovf_set",  64'(ovf_err),    64'(4'b0100));
    chk("ovf_pend", 64'(fu_pending), 64'(4'b0100));
    tick();
    chk("ovf_sticky", 64'(ovf_err), 64'(4'b0100));
    chk_cdb("ovf_hold", 32'h61, 5'd5, 2'd1);
    wb_ready = 1'b1;
    tick();
    chk_cdb("ovf_orig", 32'h62, 5'd6, 2'd2);
    tick();
    chk("ovf_idle",    64'(cdb_valid), 64'(0));
    chk("ovf_sticky2", 64'(ovf_err),   64'(4'b0100));

    // Drain plus recapture on the same slot in the same cycle
    set_fu(1, 32'h71, 5'd8);
    push(32'h71, 5'd8, 2'd1);
    tick();
    set_fu(1, 32'h99, 5'd10);
    push(32'h99, 5'd10, 2'd1);
    tick();
    fu_finish = '0;
    chk_cdb("rc_first", 32'h71, 5'd8, 2'd1);
    chk("rc_pend", 64'(fu_pending), 64'(4'b0010));
    chk("rc_ovf",  64'(ovf_err),    64'(4'b0100));
    tick();
    chk_cdb("rc_second", 32'h99, 5'd10, 2'd1);
    tick();
    chk("rc_idle", 64'(cdb_valid), 64'(0));

    // Reset mid-operation with three slots pending and a stalled CDB word
    wb_ready = 1'b0;
    set_fu(0, 32'h80, 5'd11);
    set_fu(1, 32'h81, 5'd12);
    set_fu(2, 32'h82, 5'd13);
    tick();
    fu_finish = '0;
    set_fu(2, 32'h83, 5'd14);
    tick();
    fu_finish = '0;
    chk("mr_pend",  64'(fu_pending), 64'(4'b0111));
    chk("mr_valid", 64'(cdb_valid),  64'(1));
    rst_n = 1'b0;
    tick();
    chk("mr_rst_valid", 64'(cdb_valid),  64'(0));
    chk("mr_rst_data",  64'(cdb_data),   64'(0));
    chk("mr_rst_tag",   64'(cdb_tag),    64'(0));
    chk("mr_rst_src",   64'(cdb_src),    64'(0));
    chk("mr_rst_pend",  64'(fu_pending), 64'(0));
    chk("mr_rst_ovf",   64'(ovf_err),    64'(0));
    rst_n    = 1'b1;
    wb_ready = 1'b1;
    set_fu(0, 32'hA0, 5'd2);
    push(32'hA0, 5'd2, 2'd0);
    tick();
    fu_finish = '0;
    chk("mr_slot", 64'(fu_pending), 64'(4'b0001));
    tick();
    chk_cdb("mr_after", 32'hA0, 5'd2, 2'd0);

    // Bounded drain of anything still expected
    for (int k = 0; k < 50 && (exp_q.size() != 0 || cdb_valid); k++) tick();
    chk("sb_left", 64'(exp_q.size()), 64'(0));
    chk("end_idle", 64'(cdb_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
